// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer between the CPU control unit and a combinational ALU.
// Latches one request, strobes one ALU control line for a settle window, then captures Z.
module alu_op_sequencer #(
    parameter int unsigned MULDIV_WAIT = 2,
    parameter int unsigned BASIC_WAIT  = 0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [4:0]  i_opcode,
    input  logic [31:0] i_ra_data,
    input  logic [31:0] i_rb_data,
    input  logic        i_pc_inc_req,
    input  logic [31:0] i_pc_value,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [13:0] o_alu_ctl,
    input  logic [31:0] i_alu_chigh,
    input  logic [31:0] i_alu_clow,
    output logic [31:0] o_zlow,
    output logic [31:0] o_zhigh,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pc_done,
    output logic        o_illegal
);

    localparam int unsigned CtlAdd  = 13;
    localparam int unsigned CtlSub  = 12;
    localparam int unsigned CtlMul  = 11;
    localparam int unsigned CtlDiv  = 10;
    localparam int unsigned CtlAnd  = 9;
    localparam int unsigned CtlOr   = 8;
    localparam int unsigned CtlShr  = 7;
    localparam int unsigned CtlShra = 6;
    localparam int unsigned CtlShl  = 5;
    localparam int unsigned CtlRor  = 4;
    localparam int unsigned CtlRol  = 3;
    localparam int unsigned CtlNeg  = 2;
    localparam int unsigned CtlNot  = 1;
    localparam int unsigned CtlInc  = 0;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic [13:0] r_ctl;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_zlow;
    logic [31:0] r_zhigh;
    logic        r_busy;
    logic        r_done;
    logic        r_pc_done;
    logic        r_illegal;

    logic [13:0] w_dec_ctl;
    logic [3:0]  w_dec_wait;

    always_comb begin
        w_dec_ctl = '0;
        case (i_opcode)
            5'b00011: w_dec_ctl[CtlAdd]  = 1'b1;
            5'b00100: w_dec_ctl[CtlSub]  = 1'b1;
            5'b00101: w_dec_ctl[CtlShr]  = 1'b1;
            5'b00110: w_dec_ctl[CtlShra] = 1'b1;
            5'b00111: w_dec_ctl[CtlShl]  = 1'b1;
            5'b01000: w_dec_ctl[CtlRor]  = 1'b1;
            5'b01001: w_dec_ctl[CtlRol]  = 1'b1;
            5'b01010: w_dec_ctl[CtlAnd]  = 1'b1;
            5'b01011: w_dec_ctl[CtlOr]   = 1'b1;
            5'b01111: w_dec_ctl[CtlMul]  = 1'b1;
            5'b10000: w_dec_ctl[CtlDiv]  = 1'b1;
            5'b10001: w_dec_ctl[CtlNeg]  = 1'b1;
            5'b10010: w_dec_ctl[CtlNot]  = 1'b1;
            default:  w_dec_ctl = '0;
        endcase

        if (w_dec_ctl[CtlMul] || w_dec_ctl[CtlDiv]) begin
            w_dec_wait = 4'(MULDIV_WAIT);
        end else if (|w_dec_ctl) begin
            w_dec_wait = 4'(BASIC_WAIT);
        end else begin
            w_dec_wait = 4'd0;
        end
    end

    // The latched strobe doubles as the op record: an all-zero strobe marks an illegal op.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_ctl     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_zlow    <= '0;
            r_zhigh   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pc_done <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_pc_inc_req) begin
                        r_a     <= '0;
                        r_b     <= i_pc_value;
                        r_ctl   <= 14'b1 << CtlInc;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= StExec;
                    end else if (i_start) begin
                        r_a     <= i_ra_data;
                        r_b     <= i_rb_data;
                        r_ctl   <= w_dec_ctl;
                        r_cnt   <= w_dec_wait;
                        r_busy  <= 1'b1;
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    if (r_cnt == 4'd0) begin
                        if (r_ctl != '0) begin
                            r_zlow <= i_alu_clow;
                        end
                        if (r_ctl[CtlMul] || r_ctl[CtlDiv]) begin
                            r_zhigh <= i_alu_chigh;
                        end
                        r_ctl     <= '0;
                        r_done    <= ~r_ctl[CtlInc];
                        r_pc_done <= r_ctl[CtlInc];
                        r_illegal <= (r_ctl == '0);
                        r_state   <= StDone;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StDone: begin
                    r_done    <= 1'b0;
                    r_pc_done <= 1'b0;
                    r_illegal <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_alu_a   = r_a;
    assign o_alu_b   = r_b;
    assign o_alu_ctl = r_ctl;
    assign o_zlow    = r_zlow;
    assign o_zhigh   = r_zhigh;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_pc_done = r_pc_done;
    assign o_illegal = r_illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU stub, directed table, corner sequences and
// random ops checked against an opcode-level reference model.
module tb_alu_op_sequencer;

    localparam int unsigned WMD = 2;
    localparam int unsigned WB  = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pc_req;
    logic [4:0]  opcode;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] pcv;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [13:0] ctl;
    logic [31:0] chigh;
    logic [31:0] clow;
    logic [31:0] zlow;
    logic [31:0] zhigh;
    logic        busy;
    logic        done;
    logic        pc_done;
    logic        illegal;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_zlow;
    logic [31:0] m_zhigh;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .MULDIV_WAIT(WMD),
        .BASIC_WAIT (WB)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_opcode    (opcode),
        .i_ra_data   (ra),
        .i_rb_data   (rb),
        .i_pc_inc_req(pc_req),
        .i_pc_value  (pcv),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_ctl   (ctl),
        .i_alu_chigh (chigh),
        .i_alu_clow  (clow),
        .o_zlow      (zlow),
        .o_zhigh     (zhigh),
        .o_busy      (busy),
        .o_done      (done),
        .o_pc_done   (pc_done),
        .o_illegal   (illegal)
    );

    // Combinational ALU stand-in driven by the one-hot strobes; idle output is a marker value.
    function automatic logic [63:0] alu_stub(input logic [13:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] p;
        logic [4:0]  s;
        s = b[4:0];
        if (c[13]) return {32'h0, a + b};
        if (c[12]) return {32'h0, a - b};
        if (c[11]) begin
            p = {32'h0, a} * {32'h0, b};
            return p;
        end
        if (c[10]) return (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        if (c[9]) return {32'h0, a & b};
        if (c[8]) return {32'h0, a | b};
        if (c[7]) return {32'h0, a >> s};
        if (c[6]) return {32'h0, 32'($signed(a) >>> s)};
        if (c[5]) return {32'h0, a << s};
        if (c[4]) begin
            p = {a, a} >> s;
            return {32'h0, p[31:0]};
        end
        if (c[3]) begin
            p = {a, a} << s;
            return {32'h0, p[63:32]};
        end
        if (c[2]) return {32'h0, 32'h0 - b};
        if (c[1]) return {32'h0, ~b};
        if (c[0]) return {32'h0, b + 32'd1};
        return {32'hDEAD_BEEF, 32'hDEAD_BEEF};
    endfunction

    assign {chigh, clow} = alu_stub(ctl, alu_a, alu_b);

    // Reference: strobe index (-1 = illegal) and result computed straight from the opcode.
    task automatic model(input bit is_pc, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int idx, output logic [31:0] lo,
                         output logic [31:0] hi);
        logic [63:0] wide;
        int          sh;
        sh  = int'(b[4:0]);
        hi  = 32'h0;
        lo  = 32'h0;
        idx = -1;
        if (is_pc) begin
            idx = 0;
            lo  = b + 1;
        end else begin
            case (op)
                5'd3:  begin idx = 13; lo = a + b; end
                5'd4:  begin idx = 12; lo = a - b; end
                5'd5:  begin idx = 7;  lo = a >> sh; end
                5'd6:  begin idx = 6;  lo = 32'($signed(a) >>> sh); end
                5'd7:  begin idx = 5;  lo = a << sh; end
                5'd8:  begin idx = 4;  lo = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh))); end
                5'd9:  begin idx = 3;  lo = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh))); end
                5'd10: begin idx = 9;  lo = a & b; end
                5'd11: begin idx = 8;  lo = a | b; end
                5'd15: begin
                    idx  = 11;
                    wide = 64'(a) * 64'(b);
                    lo   = wide[31:0];
                    hi   = wide[63:32];
                end
                5'd16: begin
                    idx = 10;
                    lo  = (b == 0) ? 32'hFFFF_FFFF : a / b;
                    hi  = (b == 0) ? a : a % b;
                end
                5'd17: begin idx = 2; lo = -b; end
                5'd18: begin idx = 1; lo = ~b; end
                default: idx = -1;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " alu_a"}, 64'(alu_a), 64'h0);
        chk({tag, " alu_b"}, 64'(alu_b), 64'h0);
        chk({tag, " ctl"}, 64'(ctl), 64'h0);
        chk({tag, " zlow"}, 64'(zlow), 64'h0);
        chk({tag, " zhigh"}, 64'(zhigh), 64'h0);
        chk({tag, " flags"}, 64'({busy, done, pc_done, illegal}), 64'h0);
    endtask

    // Issues one request from IDLE and checks every cycle until IDLE returns.
    task automatic run_op(input bit is_pc, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int          idx;
        int          w;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] ea;
        logic [13:0] ectl;
        ea = is_pc ? 32'h0 : a;
        model(is_pc, op, ea, b, idx, lo, hi);
        ectl = '0;
        if (idx >= 0) ectl[idx] = 1'b1;
        w = (idx == 11 || idx == 10) ? WMD : ((idx <= 0) ? 0 : WB);
        if (is_pc) begin
            pc_req = 1'b1;
            pcv    = b;
            ra     = $urandom;
            rb     = $urandom;
        end else begin
            start  = 1'b1;
            opcode = op;
            ra     = a;
            rb     = b;
            pcv    = $urandom;
        end
        tick();
        start  = 1'b0;
        pc_req = 1'b0;
        chk("accept busy", 64'(busy), 64'h1);
        chk("accept alu_a", 64'(alu_a), 64'(ea));
        chk("accept alu_b", 64'(alu_b), 64'(b));
        chk("accept ctl", 64'(ctl), 64'(ectl));
        for (int k = 0; k < w; k++) begin
            tick();
            chk("exec ctl", 64'(ctl), 64'(ectl));
            chk("exec done", 64'({done, pc_done}), 64'h0);
        end
        tick();
        if (idx >= 0) m_zlow = lo;
        if (idx == 11 || idx == 10) m_zhigh = hi;
        chk("done ctl", 64'(ctl), 64'h0);
        chk("done flags", 64'({done, pc_done, illegal}), 64'({!is_pc, is_pc, idx < 0}));
        chk("zlow", 64'(zlow), 64'(m_zlow));
        chk("zhigh", 64'(zhigh), 64'(m_zhigh));
        tick();
        chk("idle flags", 64'({busy, done, pc_done, illegal}), 64'h0);
    endtask

    typedef struct {
        bit          is_pc;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] zl;
        logic [31:0] zh;
    } vec_t;

    vec_t        tbl[13];
    logic [4:0]  legal_ops[13];
    logic [4:0]  rop;
    bit          rpc;

    initial begin
        tbl[0]  = '{0, 5'b00011, 32'd5, 32'd7, 32'd12, 32'd0};
        tbl[1]  = '{0, 5'b01111, 32'd6, 32'd7, 32'd42, 32'd0};
        tbl[2]  = '{0, 5'b01010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'd0};
        tbl[3]  = '{0, 5'b01111, 32'h0001_0000, 32'h0003_0000, 32'd0, 32'd3};
        tbl[4]  = '{0, 5'b00011, 32'd1, 32'd2, 32'd3, 32'd3};
        tbl[5]  = '{0, 5'b11111, 32'd9, 32'd9, 32'd3, 32'd3};
        tbl[6]  = '{1, 5'b00000, 32'd0, 32'h10, 32'h11, 32'd3};
        tbl[7]  = '{0, 5'b10000, 32'd100, 32'd7, 32'd14, 32'd2};
        tbl[8]  = '{0, 5'b00100, 32'd10, 32'd3, 32'd7, 32'd2};
        tbl[9]  = '{0, 5'b01000, 32'd1, 32'd1, 32'h8000_0000, 32'd2};
        tbl[10] = '{0, 5'b00110, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'd2};
        tbl[11] = '{0, 5'b10010, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd2};
        tbl[12] = '{0, 5'b00000, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd2};
        legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16,
                      5'd17, 5'd18};

        rst    = 1'b1;
        start  = 1'b0;
        pc_req = 1'b0;
        opcode = '0;
        ra     = '0;
        rb     = '0;
        pcv    = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst     = 1'b0;
        m_zlow  = '0;
        m_zhigh = '0;

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].is_pc, tbl[i].op, tbl[i].a, tbl[i].b);
            chk($sformatf("table%0d zlow", i), 64'(zlow), 64'(tbl[i].zl));
            chk($sformatf("table%0d zhigh", i), 64'(zhigh), 64'(tbl[i].zh));
        end

        // Both requests together: PC first, the still-high start is taken at E3.
        start  = 1'b1;
        opcode = 5'b00100;
        ra     = 32'd9;
        rb     = 32'd4;
        pc_req = 1'b1;
        pcv    = 32'h10;
        tick();
        pc_req = 1'b0;
        chk("both ctl", 64'(ctl), 64'h1);
        chk("both alu_a", 64'(alu_a), 64'h0);
        chk("both alu_b", 64'(alu_b), 64'h10);
        tick();
        chk("both pc_done", 64'({done, pc_done}), 64'b01);
        chk("both zlow pc", 64'(zlow), 64'h11);
        tick();
        chk("both idle", 64'(busy), 64'h0);
        tick();
        start = 1'b0;
        chk("both accept2", 64'({busy, ctl}), 64'({1'b1, 14'h1000}));
        chk("both alu_a2", 64'(alu_a), 64'd9);
        tick();
        chk("both done", 64'({done, pc_done}), 64'b10);
        chk("both zlow sub", 64'(zlow), 64'd5);
        m_zlow = 32'd5;
        tick();
        chk("both end", 64'(busy), 64'h0);

        // Reset during the second EXEC cycle of a DIV.
        start  = 1'b1;
        opcode = 5'b10000;
        ra     = 32'd50;
        rb     = 32'd5;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("midreset");
        m_zlow  = '0;
        m_zhigh = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post reset quiet", 64'({busy, done, pc_done}), 64'h0);
        end
        run_op(1'b0, 5'b00011, 32'd20, 32'd22);

        // Continuous start: one SUB every three cycles.
        start  = 1'b1;
        opcode = 5'b00100;
        ra     = 32'd10;
        rb     = 32'd3;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("held done", 64'(done), 64'((k % 3) == 1));
            chk("held busy", 64'(busy), 64'((k % 3) != 2));
            chk("held onehot", 64'($countones(ctl) <= 1), 64'h1);
            if ((k % 3) == 0) chk("held ctl", 64'(ctl), 64'h1000);
            if ((k % 3) == 1) chk("held zlow", 64'(zlow), 64'd7);
            if (k == 8) start = 1'b0;
        end
        m_zlow = 32'd7;

        for (int i = 0; i < 60; i++) begin
            rpc = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) rop = 5'($urandom_range(0, 31));
            else rop = legal_ops[$urandom_range(0, 12)];
            run_op(rpc, rop, $urandom, ($urandom_range(0, 1) == 1) ? $urandom :
                   32'($urandom_range(0, 40)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
